// File: rtl/ta259_seq_bar_pkg.sv
// Shared types and constants for the ta259_seq_bar addressable latch / demux.
package ta259_seq_bar_pkg;

    // Serial frame loader states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Direct-write modes, encoded as {CLR_BAR, EN_BAR}.
    localparam logic [1:0] MODE_DEMUX = 2'b00;
    localparam logic [1:0] MODE_CLEAR = 2'b01;
    localparam logic [1:0] MODE_LATCH = 2'b10;
    localparam logic [1:0] MODE_MEM   = 2'b11;

endpackage

// File: rtl/ta259_seq_bar_addr_latch_core.sv
// Output register with the four 74x259 direct modes and a whole-word
// override used by the serial loader to commit a frame atomically.
module ta259_seq_bar_addr_latch_core
    import ta259_seq_bar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SELW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_bar,
    input  logic             en_bar,
    input  logic [SELW-1:0]  sel,
    input  logic             d,
    input  logic             load_all,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next Q: a frame commit wins over whatever direct mode is presented.
    always_comb begin
        q_d = q_q;
        if (load_all) begin
            q_d = load_val;
        end else begin
            unique case ({clr_bar, en_bar})
                MODE_LATCH: q_d[sel] = d;
                MODE_MEM:   q_d = q_q;
                MODE_DEMUX: begin
                    q_d      = '0;
                    q_d[sel] = d;
                end
                MODE_CLEAR: q_d = '0;
                default:    q_d = q_q;
            endcase
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ta259_seq_bar.sv
// 8-line addressable latch / 1-to-8 demux with a serial frame loader.
// Handshake: a serial bit is transferred on a rising edge where SIN_VALID and
// SIN_READY are both high; SIN_READY is high only in LOAD and never depends
// combinationally on SIN_VALID, so the source may hold SIN_VALID freely.
module ta259_seq_bar
    import ta259_seq_bar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SELW  = 3
) (
    input  logic             CLK,
    input  logic             RST_BAR,
    input  logic             EN_BAR,
    input  logic             CLR_BAR,
    input  logic [SELW-1:0]  SEL,
    input  logic             D,
    input  logic             START,
    input  logic             ABORT,
    input  logic             SIN,
    input  logic             SIN_VALID,
    output logic             SIN_READY,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output ld_state_e        STATE_DBG
);

    localparam logic [SELW-1:0] LAST_IDX = SELW'(WIDTH - 1);

    ld_state_e        state_q, state_d;
    logic [SELW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             commit;
    logic [WIDTH-1:0] commit_val;

    // Loader next-state: ABORT beats an accept, the last accept commits.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        commit     = 1'b0;
        commit_val = {SIN, shadow_q[WIDTH-2:0]};
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (SIN_VALID) begin
                    shadow_d[count_q] = SIN;
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader state, bit counter and shadow frame.
    always_ff @(posedge CLK or negedge RST_BAR) begin
        if (!RST_BAR) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end

    ta259_seq_bar_addr_latch_core #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_core (
        .clk      (CLK),
        .rst_n    (RST_BAR),
        .clr_bar  (CLR_BAR),
        .en_bar   (EN_BAR),
        .sel      (SEL),
        .d        (D),
        .load_all (commit),
        .load_val (commit_val),
        .q        (Q)
    );

    // Status outputs are pure decodes of the state register.
    assign SIN_READY = (state_q == ST_LOAD);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_DONE);
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_ta259_seq_bar.sv
// Directed bench for ta259_seq_bar: direct modes, serial frames, abort,
// commit priority and asynchronous reset mid-frame.
module tb_ta259_seq_bar;
    import ta259_seq_bar_pkg::*;

    logic       clk;
    logic       rst_bar;
    logic       en_bar;
    logic       clr_bar;
    logic [2:0] sel;
    logic       d;
    logic       start;
    logic       abort;
    logic       sin;
    logic       sin_valid;
    logic       sin_ready;
    logic [7:0] q;
    logic       busy;
    logic       done;
    ld_state_e  state_dbg;

    int n_checks;
    int n_fail;

    ta259_seq_bar #(.WIDTH(8), .SELW(3)) dut (
        .CLK       (clk),
        .RST_BAR   (rst_bar),
        .EN_BAR    (en_bar),
        .CLR_BAR   (clr_bar),
        .SEL       (sel),
        .D         (d),
        .START     (start),
        .ABORT     (abort),
        .SIN       (sin),
        .SIN_VALID (sin_valid),
        .SIN_READY (sin_ready),
        .Q         (q),
        .BUSY      (busy),
        .DONE      (done),
        .STATE_DBG (state_dbg)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_bar = 1'b0; en_bar = 1'b1; clr_bar = 1'b1; sel = '0; d = 1'b0;
        start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        #2;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", q); end
        n_checks++; if (sin_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", sin_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        tick(); tick();
        rst_bar = 1'b1;
        tick();
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL post_reset_q: got %h expected 00", q); end
    endtask

    task automatic test_latch();
        clr_bar = 1'b1; en_bar = 1'b0; sel = 3'd5; d = 1'b1;
        tick();
        n_checks++; if (q !== 8'h20) begin n_fail++; $display("FAIL latch_sel5: got %h expected 20", q); end
        sel = 3'd0; d = 1'b1;
        tick();
        n_checks++; if (q !== 8'h21) begin n_fail++; $display("FAIL latch_sel0: got %h expected 21", q); end
        en_bar = 1'b1; sel = 3'd7; d = 1'b1;
        tick(); tick();
        n_checks++; if (q !== 8'h21) begin n_fail++; $display("FAIL memory_hold: got %h expected 21", q); end
        en_bar = 1'b0; sel = 3'd5; d = 1'b0;
        tick();
        n_checks++; if (q !== 8'h01) begin n_fail++; $display("FAIL latch_write0: got %h expected 01", q); end
        en_bar = 1'b1;
    endtask

    task automatic test_demux_clear();
        clr_bar = 1'b1; en_bar = 1'b0; d = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
        end
        n_checks++; if (q !== 8'hFF) begin n_fail++; $display("FAIL fill_ff: got %h expected ff", q); end
        clr_bar = 1'b0; en_bar = 1'b0; sel = 3'd3; d = 1'b1;
        tick();
        n_checks++; if (q !== 8'h08) begin n_fail++; $display("FAIL demux_sel3: got %h expected 08", q); end
        clr_bar = 1'b0; en_bar = 1'b1;
        tick();
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL clear: got %h expected 00", q); end
        clr_bar = 1'b1; en_bar = 1'b1;
    endtask

    // Plays one frame (line 0 first) with optional one-cycle gaps after bits.
    task automatic run_frame(input logic [7:0] bits, input logic [7:0] gaps,
                             input int exp_done_cyc, input string tag);
        int cyc;
        logic [7:0] q_before;
        q_before = q;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        n_checks++; if (busy !== 1'b1 || sin_ready !== 1'b1) begin n_fail++; $display("FAIL %s_enter_load: busy=%b ready=%b expected 1 1", tag, busy, sin_ready); end
        for (int i = 0; i < 8; i++) begin
            sin = bits[i]; sin_valid = 1'b1;
            tick(); cyc++;
            sin_valid = 1'b0;
            if (i < 7) begin
                n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL %s_mid_bit%0d: done=%b busy=%b expected 0 1", tag, i, done, busy); end
            end
            if (i == 3) begin
                n_checks++; if (q !== q_before) begin n_fail++; $display("FAIL %s_q_during_load: got %h expected %h", tag, q, q_before); end
            end
            if (gaps[i]) begin
                sin = ~bits[i];
                tick(); cyc++;
                n_checks++; if (done !== 1'b0 || sin_ready !== 1'b1) begin n_fail++; $display("FAIL %s_gap%0d: done=%b ready=%b expected 0 1", tag, i, done, sin_ready); end
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b expected 1", tag, done); end
        n_checks++; if (cyc !== exp_done_cyc) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", tag, cyc, exp_done_cyc); end
        n_checks++; if (q !== bits) begin n_fail++; $display("FAIL %s_q: got %h expected %h", tag, q, bits); end
        n_checks++; if (sin_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL %s_done_flags: ready=%b busy=%b expected 0 1", tag, sin_ready, busy); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", tag, done, busy); end
    endtask

    task automatic test_frame();
        // bits 1,0,1,1,0,0,1,0 on lines 0..7
        run_frame(8'h4D, 8'h00, 9, "frame");
    endtask

    task automatic test_frame_stall();
        clr_bar = 1'b0; en_bar = 1'b1;
        tick();
        clr_bar = 1'b1;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL stall_preclear: got %h expected 00", q); end
        // gaps after the 2nd and 5th bits
        run_frame(8'h4D, 8'h12, 11, "stall");
    endtask

    task automatic test_abort();
        logic [7:0] pat;
        pat = 8'hA5;
        clr_bar = 1'b1; en_bar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); d = pat[i];
            tick();
        end
        en_bar = 1'b1;
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL abort_setup: got %h expected a5", q); end
        // abort after four bits
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin = 1'b1; sin_valid = 1'b1; tick();
        end
        abort = 1'b1; tick(); abort = 1'b0; sin_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || sin_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%b ready=%b expected 0 0", busy, sin_ready); end
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL abort_q: got %h expected a5", q); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done%0d: got %b expected 0", i, done); end
        end
        // abort coinciding with the last accept
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sin = 1'b0; sin_valid = 1'b1;
            if (i == 7) abort = 1'b1;
            tick();
        end
        abort = 1'b0; sin_valid = 1'b0;
        n_checks++; if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_last: q=%h busy=%b done=%b expected a5 0 0", q, busy, done); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_last_no_done: got %b expected 0", done); end
        // direct write mid-frame, then direct clear on the commit edge
        pat = 8'h3C;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sin = pat[i]; sin_valid = 1'b1;
            if (i == 2) begin en_bar = 1'b0; sel = 3'd1; d = 1'b1; end
            if (i == 7) begin clr_bar = 1'b0; en_bar = 1'b1; end
            tick();
            en_bar = 1'b1;
            if (i == 2) begin
                n_checks++; if (q !== 8'hA7) begin n_fail++; $display("FAIL load_direct_write: got %h expected a7", q); end
            end
        end
        sin_valid = 1'b0; clr_bar = 1'b1;
        n_checks++; if (q !== 8'h3C || done !== 1'b1) begin n_fail++; $display("FAIL commit_over_clear: q=%h done=%b expected 3c 1", q, done); end
        tick();
        n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL commit_hold: got %h expected 3c", q); end
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin = 1'b1; sin_valid = 1'b1; tick();
        end
        @(posedge clk);
        #3;
        rst_bar = 1'b0;
        #1;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rst_mid_q: got %h expected 00", q); end
        n_checks++; if (sin_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: ready=%b busy=%b done=%b expected 0 0 0", sin_ready, busy, done); end
        tick();
        rst_bar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sin = 1'($urandom_range(0, 1));
            tick();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after%0d: done=%b busy=%b expected 0 0", i, done, busy); end
        end
        sin_valid = 1'b0;
    endtask

    // Test sequence and final report.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_latch();
        test_demux_clear();
        test_frame();
        test_frame_stall();
        test_abort();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
